// File: rtl/score_scan_n.sv
// Multi-channel BCD scoreboard with multiplexed, leading-zero-blanked 7-segment scan.
// Latency: point rise -> score_bcd 2 cycles; index change -> seg/scan_en 1 cycle.
// Backpressure: none; point is a level input and edges are never queued.
// Ports: clk_25MHz (sole clock), reset (sync active-low full reset),
//        reset_game (sync active-low score/win clear, scan keeps running),
//        point[NUM_PLAYERS] (rising edge = +1), score_bcd (packed BCD, ch0 in LSBs),
//        win (one-hot winner), game_over, seg (active-low {g,f,e,d,c,b,a}),
//        scan_en (active-low one-hot digit enable).
// Option: define SCORE_BLINK_EN to blink the winner's digits in 2^24-cycle periods.
module score_scan_n #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2,
  parameter int WIN_SCORE   = 11,
  parameter int SCAN_DIV    = 25000
) (
  input  logic                            clk_25MHz,
  input  logic                            reset,
  input  logic                            reset_game,
  input  logic [NUM_PLAYERS-1:0]          point,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd,
  output logic [NUM_PLAYERS-1:0]          win,
  output logic                            game_over,
  output logic [6:0]                      seg,
  output logic [NUM_PLAYERS*DIGITS-1:0]   scan_en
);

  localparam int ND = NUM_PLAYERS * DIGITS;
  localparam int SW = DIGITS * 4;
  localparam int IW = $clog2(ND);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(ND - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  function automatic logic [SW-1:0] to_bcd(input int n);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'((n / (10 ** i)) % 10);
    return r;
  endfunction

  localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

  // Ripple BCD increment; a carry out of the top digit means all nines, so hold.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return carry ? v : r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // ---------------- scoring ----------------
  logic [NUM_PLAYERS-1:0]         point_r, point_d, pt_edge;
  logic [NUM_PLAYERS-1:0][SW-1:0] score, score_nxt;
  logic [NUM_PLAYERS-1:0]         win_nxt;
  logic                           won;

  assign pt_edge   = point_r & ~point_d;
  assign score_bcd = score;
  assign game_over = |win;

  // Channels are scanned low to high so the lowest index claims a shared win.
  always_comb begin
    score_nxt = score;
    win_nxt   = win;
    won       = 1'b0;
    if (!game_over) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (pt_edge[i]) begin
          score_nxt[i] = bcd_inc(score[i]);
          if (WIN_SCORE != 0 && !won && score_nxt[i] == WIN_BCD) begin
            win_nxt[i] = 1'b1;
            won        = 1'b1;
          end
        end
      end
    end
  end

  // Edge registers clear to zero so a point held through reset still scores once.
  always_ff @(posedge clk_25MHz) begin
    if (!reset || !reset_game) begin
      point_r <= '0;
      point_d <= '0;
      score   <= '0;
      win     <= '0;
    end else begin
      point_r <= point;
      point_d <= point_r;
      score   <= score_nxt;
      win     <= win_nxt;
    end
  end

`ifdef SCORE_BLINK_EN
  logic [24:0] blink_cnt;

  always_ff @(posedge clk_25MHz) begin
    if (!reset || !reset_game) blink_cnt <= '0;
    else                       blink_cnt <= blink_cnt + 25'd1;
  end
`endif

  // ---------------- display scan ----------------
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_nxt;
  logic [ND-1:0] scan_nxt;

  // A non-units digit is blank when it and every more significant digit are zero.
  always_comb begin
    nib   = '0;
    blank = 1'b0;
    for (int k = 0; k < ND; k++) begin
      if (idx == IW'(k)) begin
        nib   = score[k / DIGITS][(k % DIGITS)*4 +: 4];
        blank = (k % DIGITS) != 0;
        for (int j = 0; j < DIGITS; j++) begin
          if (j >= (k % DIGITS) && score[k / DIGITS][j*4 +: 4] != 4'd0) blank = 1'b0;
        end
`ifdef SCORE_BLINK_EN
        if (blink_cnt[24] && win[k / DIGITS]) blank = 1'b1;
`endif
      end
    end
    seg_nxt  = blank ? 7'h7F : seg_decode(nib);
    scan_nxt = ~(ND'(1) << idx);
  end

  always_ff @(posedge clk_25MHz) begin
    if (!reset) begin
      pre     <= '0;
      idx     <= '0;
      seg     <= 7'h7F;
      scan_en <= '1;
    end else begin
      if (pre == PRE_LAST) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        pre <= pre + PW'(1);
      end
      seg     <= seg_nxt;
      scan_en <= scan_nxt;
    end
  end

endmodule

// File: tb/tb_score_scan_n.sv
module tb_score_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: win detection at 11. Instance B: win detection disabled.
  logic        a_reset, a_reset_game, b_reset, b_reset_game;
  logic [1:0]  a_point, b_point;
  logic [15:0] a_score, b_score;
  logic [1:0]  a_win, b_win;
  logic        a_go, b_go;
  logic [6:0]  a_seg, b_seg;
  logic [3:0]  a_scan, b_scan;

  score_scan_n #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .SCAN_DIV(4)) dut_a (
    .clk_25MHz(clk), .reset(a_reset), .reset_game(a_reset_game), .point(a_point),
    .score_bcd(a_score), .win(a_win), .game_over(a_go), .seg(a_seg), .scan_en(a_scan)
  );

  score_scan_n #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0), .SCAN_DIV(4)) dut_b (
    .clk_25MHz(clk), .reset(b_reset), .reset_game(b_reset_game), .point(b_point),
    .score_bcd(b_score), .win(b_win), .game_over(b_go), .seg(b_seg), .scan_en(b_scan)
  );

  typedef struct packed {
    int          due;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  chk_t mon_c;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   c_rel = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return {16'b0, a_score};
      1:       return {30'b0, a_win};
      2:       return {31'b0, a_go};
      3:       return {25'b0, a_seg};
      4:       return {28'b0, a_scan};
      5:       return {16'b0, b_score};
      6:       return {30'b0, b_win};
      default: return 32'b0;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0:       return "a_score_bcd";
      1:       return "a_win";
      2:       return "a_game_over";
      3:       return "a_seg";
      4:       return "a_scan_en";
      5:       return "b_score_bcd";
      6:       return "b_win";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: pops every expectation that has come due and compares on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_c = q.pop_front();
      n_cmp++;
      if (actual(mon_c.sel) !== mon_c.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                 sel_name(mon_c.sel), actual(mon_c.sel), mon_c.exp, cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int sel, input logic [31:0] exp, input int dly);
    chk_t c;
    c.due = cyc + dly;
    c.sel = sel;
    c.exp = exp;
    q.push_back(c);
  endtask

  task automatic pulse_a(input logic [1:0] m);
    a_point = m;
    tick(1);
    a_point = 2'b00;
    tick(1);
  endtask

  task automatic pulse_b(input logic [1:0] m);
    b_point = m;
    tick(1);
    b_point = 2'b00;
    tick(1);
  endtask

  // Bench model of instance A's scan: digit k is on display during cycles
  // r = 1+4k .. 4+4k (mod 16) after reset release.
  function automatic int shown_digit();
    return ((cyc - c_rel - 1) / 4) % 4;
  endfunction

  task automatic check_digit(input int k, input logic [6:0] s);
    logic [3:0] m;
    tick(1);
    while (shown_digit() != k) tick(1);
    m = ~(4'b0001 << k);
    push(4, {28'b0, m}, 0);
    push(3, {25'b0, s}, 0);
  endtask

  initial begin
    a_reset = 1'b0; a_reset_game = 1'b1; a_point = 2'b00;
    b_reset = 1'b0; b_reset_game = 1'b1; b_point = 2'b10;
    tick(3);

    // reset state
    push(0, 32'h0, 0); push(1, 32'h0, 0); push(2, 32'h0, 0);
    push(3, 32'h7F, 0); push(4, 32'hF, 0); push(5, 32'h0, 0);

    // scan walk with zero scores: units show 0, tens blanked
    a_reset = 1'b1;
    c_rel   = cyc;
    tick(1);
    push(0, 32'h0, 0); push(1, 32'h0, 0);
    push(4, 32'hE, 0);  push(3, 32'h40, 0);
    push(4, 32'hD, 4);  push(3, 32'h7F, 4);
    push(4, 32'hB, 8);  push(3, 32'h40, 8);
    push(4, 32'h7, 12); push(3, 32'h7F, 12);
    push(4, 32'hE, 16);
    tick(17);

    // ten points on channel 0, carry into tens
    repeat (9) pulse_a(2'b01);
    push(0, 32'h0009, 0);
    pulse_a(2'b01);
    push(0, 32'h0010, 0);
    check_digit(1, 7'h79);
    check_digit(0, 7'h40);

    // both channels at 10, simultaneous edge: lowest index wins
    repeat (10) pulse_a(2'b10);
    push(0, 32'h1010, 0); push(1, 32'h0, 0);
    pulse_a(2'b11);
    push(0, 32'h1111, 0); push(1, 32'h1, 0); push(2, 32'h1, 0);

    // edges ignored after game over, then game reset keeps scan phase
    repeat (3) pulse_a(2'b10);
    push(0, 32'h1111, 0); push(1, 32'h1, 0);
    a_reset_game = 1'b0;
    tick(1);
    a_reset_game = 1'b1;
    push(0, 32'h0, 0); push(1, 32'h0, 0); push(2, 32'h0, 0);
    check_digit(2, 7'h40);
    check_digit(3, 7'h7F);

    // long high level on channel 1 is a single point
    a_point = 2'b10;
    tick(100);
    a_point = 2'b00;
    tick(2);
    push(0, 32'h0100, 0);

    // score 5 on channel 0: tens blanked, units 5
    repeat (5) pulse_a(2'b01);
    push(0, 32'h0105, 0);
    check_digit(1, 7'h7F);
    check_digit(0, 7'h12);
    check_digit(2, 7'h79);
    check_digit(3, 7'h7F);

    // instance B: point held through reset release scores exactly once
    b_reset = 1'b1;
    tick(3);
    push(5, 32'h0100, 0);
    b_point = 2'b00;
    tick(1);

    // count to 99 and saturate, no win when disabled
    repeat (9) pulse_b(2'b01);
    push(5, 32'h0109, 0);
    pulse_b(2'b01);
    push(5, 32'h0110, 0);
    repeat (89) pulse_b(2'b01);
    push(5, 32'h0199, 0); push(6, 32'h0, 0);
    pulse_b(2'b01);
    push(5, 32'h0199, 0); push(6, 32'h0, 0);

    // game reset beats a pending edge; the still-high point rescores after release
    b_point = 2'b01;
    tick(1);
    b_reset_game = 1'b0;
    tick(1);
    b_reset_game = 1'b1;
    push(5, 32'h0, 0);
    tick(2);
    push(5, 32'h0001, 0);
    b_point = 2'b00;
    tick(2);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_scan_n.md
SCORE_SCAN_N -- requirements
Module: score_scan_n

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of scoring channels (legal 2..4).
REQ-002 SHALL have parameter DIGITS, default 2, BCD digits per channel (legal 1..4).
REQ-003 SHALL have parameter WIN_SCORE, default 11, winning score; 0 disables win detection; legal max 10^DIGITS-1.
REQ-004 SHALL have parameter SCAN_DIV, default 25000, clock cycles per displayed digit (1 kHz digit rate at 25 MHz).
REQ-005 SHALL have port clk_25MHz  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low full reset.
REQ-007 SHALL have port reset_game  input  1  synchronous, active-low score/win clear; scan timing kept.
REQ-008 SHALL have port point  input  NUM_PLAYERS  level signal per channel; rising edge awards that channel one point.
REQ-009 SHALL have port score_bcd  output  NUM_PLAYERS*DIGITS*4  packed BCD scores, channel 0 in LSBs, units digit lowest.
REQ-010 SHALL have port win  output  NUM_PLAYERS  one-hot winner flag, at most one bit set.
REQ-011 SHALL have port game_over  output  1  high while any win bit set.
REQ-012 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a} of the selected digit.
REQ-013 SHALL have port scan_en  output  NUM_PLAYERS*DIGITS  active-low one-hot digit enable.

Function
REQ-014 SHALL register point and detect rising edge as point=1 with previous sample 0; one edge awards exactly one point regardless of high duration.
REQ-015 SHALL increment a channel's score in BCD the cycle after its edge is detected (score_bcd valid 2 cycles after point rises).
REQ-016 SHALL carry 9->0 into the next digit; at 10^DIGITS-1 the score SHALL saturate, not wrap.
REQ-017 SHALL process edges on several channels in the same cycle independently, each channel gaining one point.
REQ-018 SHALL set win[i] on the same edge that makes score i equal WIN_SCORE (WIN_SCORE != 0); game_over follows combinationally from win.
REQ-019 SHALL, when several channels reach WIN_SCORE in the same cycle, set win only for the lowest index; all those scores still update.
REQ-020 SHALL ignore all point edges while game_over is high; scores and win hold.
REQ-021 SHALL run a scan prescaler 0..SCAN_DIV-1 wrapping; at terminal count the digit index advances 0..NUM_PLAYERS*DIGITS-1 and wraps to 0.
REQ-022 SHALL map digit index k to channel k/DIGITS, digit k%DIGITS, and drive scan_en bit k low, all others high.
REQ-023 SHALL register seg and scan_en, updating on the cycle after the index changes, so both always switch together.
REQ-024 SHALL decode 0..9 to standard 7-segment patterns and BCD 10..15 to all segments off.
REQ-025 SHALL blank leading zeros of each channel (units digit always shown).

Reset
REQ-026 SHALL on reset=0 clear scores to 0, win to 0, edge registers to 0, prescaler to 0, digit index to 0, seg to 7'h7F, scan_en to all ones.
REQ-027 SHALL on reset_game=0 (reset=1) clear scores, win and edge registers only; the scan continues uninterrupted.
REQ-028 SHALL give reset priority over reset_game, and both priority over point edges in the same cycle.
REQ-029 SHALL load edge registers with point=0 on any reset, so a point held high through reset release awards one point.

Configuration
REQ-030 SHALL use macro SCORE_BLINK_EN; when defined, the winning channel's digits SHALL be blanked (seg=7'h7F, scan_en still cycling) during alternate 2^24-cycle blink periods while game_over is high, blink counter cleared by either reset.
REQ-031 SHALL, when SCORE_BLINK_EN is undefined, display winning scores steadily with no blink counter instantiated.

Verification
REQ-032 SHALL cover: reset low then high, no point -> score_bcd=0, win=0, scan_en cycles 1110->1101->1011->0111 every SCAN_DIV cycles (SCAN_DIV=4 in bench).
REQ-033 SHALL cover: 10 edges on point[0] -> score 0x10, channel 0 tens digit shows seg for 1, units for 0.
REQ-034 SHALL cover: point[0] and point[1] both at 10, edges same cycle, WIN_SCORE=11 -> both scores 0x11, win=2'b01, game_over=1.
REQ-035 SHALL cover: after game_over, 3 edges on point[1] -> scores unchanged; reset_game low 1 cycle -> scores 0, win 0, scan index unchanged.
REQ-036 SHALL cover: point[1] held high 100 cycles -> exactly +1; DIGITS=2, 99 then one edge with WIN_SCORE=0 -> score stays 0x99.
REQ-037 SHALL cover: score 5 on channel 0 -> tens digit blanked (seg=7'h7F), units shows 5.
